mbist_march_ctrl: RTL and testbench
===================================

# mbist_march_ctrl

March C- memory built-in self-test controller for the 64x8 single-port synchronous SRAM. The block owns the SRAM port and shares it between the functional requester and the BIST engine. When idle, functional accesses pass through unchanged. When started, it runs a fixed March C- sequence, compares every read, and reports pass/fail with first-failure diagnostics.

## Interface
- ADDR_W, 6, SRAM address width; depth is 2**ADDR_W
- DATA_W, 8, SRAM data width
- BG, 8'h00, background word written for "0"; "1" is ~BG
- STOP_ON_FAIL, 1, 1: end the run at the first mismatch; 0: complete the run and record the first mismatch only
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a BIST run
- busy  out  1  BIST owns the SRAM
- done  out  1  run finished; held until the next accepted start
- pass  out  1  valid while done; 1 = no mismatch
- fail_addr  out  ADDR_W  address of the first mismatch
- fail_data  out  DATA_W  data read at the first mismatch
- fail_element  out  3  March element index (0-5) of the first mismatch
- func_addr, func_wdata, func_rwbar, func_cs  in  ADDR_W/DATA_W/1/1  functional request
- func_rdata  out  DATA_W  mem_rdata when !busy, else 0
- mem_addr, mem_wdata, mem_rwbar, mem_cs  out  ADDR_W/DATA_W/1/1  to the SRAM (rwbar: 1 = read, 0 = write)
- mem_rdata  in  DATA_W  SRAM read data

## Operation
- SRAM contract: write on posedge when cs=1 and rwbar=0. A read latches the address on posedge with cs=1 and rwbar=1. Data is valid in the following cycle only while cs=1 and rwbar=1.
- March C- elements, with direction "up" = 0 to 63 and "down" = 63 to 0:
  - E0 up (w0)
  - E1 up (r0, w1)
  - E2 up (r1, w0)
  - E3 down (r0, w1)
  - E4 down (r1, w0)
  - E5 up (r0)
- States:
  - IDLE: mem_* = func_* (combinational pass-through), busy=0.
  - WR: one cycle; cs=1, rwbar=0, wdata = BG or ~BG.
  - RD_ISS: cs=1, rwbar=1, addr driven.
  - RD_CMP: cs=1, rwbar=1, same addr held. mem_rdata is compared with the expected word at the end of this cycle.
  - DONE: same pass-through as IDLE, done=1.
- A read takes 2 cycles (RD_ISS, RD_CMP). A write takes 1 cycle.
- The operations of an element run back-to-back per address. The address then steps with no bubble. Element boundaries also have no bubble.
- Mismatch in RD_CMP:
  - On the first mismatch only, capture fail_addr, fail_data (the raw mem_rdata) and fail_element, and set the sticky fail flag.
  - STOP_ON_FAIL=1: next state is DONE.
  - STOP_ON_FAIL=0: continue the run.
- The last RD_CMP of E5 goes to DONE. pass = !fail.
- start:
  - Accepted in IDLE or DONE. Acceptance clears done, pass, the fail flag and fail_*.
  - Ignored while busy.
- While busy, func_* inputs are ignored and func_rdata = 0.
- Address counter is ADDR_W bits. Element end is detected at 63 (up) or 0 (down), never by counter wrap.

## Timing
- Reset (async assert, sync deassert at the system level):
  - state IDLE, busy=0, done=0, pass=0, fail_addr=0, fail_data=0, fail_element=0, internal counters 0.
  - mem_* follow func_* immediately.
- Reset mid-run aborts the run at once. The SRAM contents are undefined afterwards.
- start high at edge N (in IDLE or DONE):
  - busy=1 and the first E0 write is driven in cycle N+1.
- Fault-free run length: 64 + 4 x 192 + 128 = 960 busy cycles. done=1 and busy=0 in the cycle after the last busy cycle.
- Stop on fail: the mismatching RD_CMP is the last busy cycle. DONE follows in the next cycle.
- mem_* are decoded from registered state (no input-to-output path) while busy.
- pass, done and fail_* change only on clock edges.

## Test plan
- Fault-free SRAM model, start pulse -> busy high for exactly 960 cycles, then done=1, pass=1, fail_addr=0, fail_element=0; done held until the next start.
- Addr 17, bit 3 stuck-at-1, STOP_ON_FAIL=1 -> fail in E1 r0: fail_addr=17, fail_data=8'h08, fail_element=1, busy for 117 cycles, then done=1, pass=0.
- Addr 63, bit 0 stuck-at-0, STOP_ON_FAIL=0 -> run completes in 960 cycles, pass=0, fail_addr=63, fail_data=8'hFE, fail_element=2 (first failure retained despite later mismatches).
- Idle pass-through: func write 8'hA5 to addr 9, then func read -> func_rdata=8'hA5 in the cycle after read issue; start pulses during busy are ignored (run length still 960).
- rst_n asserted at busy cycle 300 -> busy=0, done=0, pass=0 immediately, mem_cs follows func_cs. A new start then yields a full 960-cycle passing run.
- Restart from DONE after a failing run -> fail_* cleared on start; fault-free model then gives pass=1.

Source files
------------

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller for a single-port synchronous SRAM. It shares the
// SRAM port with a functional requester and reports the first read mismatch.
module mbist_march_ctrl #(
  parameter int               ADDR_W       = 6,
  parameter int               DATA_W       = 8,
  parameter logic [DATA_W-1:0] BG          = '0,
  parameter bit               STOP_ON_FAIL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_data_o,
  output logic [2:0]        fail_element_o,
  input  logic [ADDR_W-1:0] func_addr_i,
  input  logic [DATA_W-1:0] func_wdata_i,
  input  logic              func_rwbar_i,
  input  logic              func_cs_i,
  output logic [DATA_W-1:0] func_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_rwbar_o,
  output logic              mem_cs_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_ISS, S_RD_CMP, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t              state_q;
  logic [2:0]          elem_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                fail_q;
  logic                done_q;
  logic                pass_q;
  logic [ADDR_W-1:0]   fail_addr_q;
  logic [DATA_W-1:0]   fail_data_q;
  logic [2:0]          fail_elem_q;

  logic                down;
  logic                last_addr;
  logic [ADDR_W-1:0]   addr_step;
  logic [2:0]          elem_next;
  logic [ADDR_W-1:0]   next_start;
  logic [DATA_W-1:0]   wr_word;
  logic [DATA_W-1:0]   exp_word;
  logic                mismatch;

  // Elements 3 and 4 walk downwards; element end is a compare, never a wrap.
  always_comb begin
    down       = (elem_q == 3'd3) || (elem_q == 3'd4);
    last_addr  = down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    addr_step  = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
    elem_next  = elem_q + 3'd1;
    next_start = ((elem_next == 3'd3) || (elem_next == 3'd4)) ? ADDR_MAX : '0;
    wr_word    = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~BG : BG;
    exp_word   = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~BG : BG;
    mismatch   = (mem_rdata_i != exp_word);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q     <= S_WR;
            elem_q      <= '0;
            addr_q      <= '0;
            fail_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_elem_q <= '0;
          end
        end
        S_WR: begin
          // A write is always the last operation of its address.
          if (last_addr) begin
            elem_q  <= elem_next;
            addr_q  <= next_start;
            state_q <= S_RD_ISS;
          end else begin
            addr_q  <= addr_step;
            state_q <= (elem_q == 3'd0) ? S_WR : S_RD_ISS;
          end
        end
        S_RD_ISS: state_q <= S_RD_CMP;
        S_RD_CMP: begin
          if (mismatch && !fail_q) begin
            fail_addr_q <= addr_q;
            fail_data_q <= mem_rdata_i;
            fail_elem_q <= elem_q;
          end
          fail_q <= fail_q | mismatch;
          if ((mismatch && STOP_ON_FAIL) || ((elem_q == 3'd5) && last_addr)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            pass_q  <= !(fail_q | mismatch);
          end else if (elem_q == 3'd5) begin
            addr_q  <= addr_step;
            state_q <= S_RD_ISS;
          end else begin
            state_q <= S_WR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q == S_WR) || (state_q == S_RD_ISS) || (state_q == S_RD_CMP);
    if (busy_o) begin
      mem_addr_o   = addr_q;
      mem_wdata_o  = wr_word;
      mem_rwbar_o  = (state_q != S_WR);
      mem_cs_o     = 1'b1;
      func_rdata_o = '0;
    end else begin
      mem_addr_o   = func_addr_i;
      mem_wdata_o  = func_wdata_i;
      mem_rwbar_o  = func_rwbar_i;
      mem_cs_o     = func_cs_i;
      func_rdata_o = mem_rdata_i;
    end
  end

  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_addr_o    = fail_addr_q;
  assign fail_data_o    = fail_data_q;
  assign fail_element_o = fail_elem_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two instances (stop-on-fail and run-to-end),
// each with a behavioural SRAM that can hold one stuck-at fault.
module tb_mbist_march_ctrl;

  localparam int AW = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start      [2];
  logic          busy       [2];
  logic          done       [2];
  logic          pass       [2];
  logic [AW-1:0] fail_addr  [2];
  logic [DW-1:0] fail_data  [2];
  logic [2:0]    fail_elem  [2];
  logic [DW-1:0] func_rdata [2];
  logic [AW-1:0] mem_addr   [2];
  logic [DW-1:0] mem_wdata  [2];
  logic          mem_rwbar  [2];
  logic          mem_cs     [2];
  logic [DW-1:0] mem_rdata  [2];

  logic [AW-1:0] func_addr;
  logic [DW-1:0] func_wdata;
  logic          func_rwbar;
  logic          func_cs;

  logic [AW-1:0] fault_addr [2];
  logic [DW-1:0] sa0_mask   [2];
  logic [DW-1:0] sa1_mask   [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      mbist_march_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .BG(8'h00), .STOP_ON_FAIL(gi == 0)
      ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start[gi]),
        .busy_o         (busy[gi]),
        .done_o         (done[gi]),
        .pass_o         (pass[gi]),
        .fail_addr_o    (fail_addr[gi]),
        .fail_data_o    (fail_data[gi]),
        .fail_element_o (fail_elem[gi]),
        .func_addr_i    (func_addr),
        .func_wdata_i   (func_wdata),
        .func_rwbar_i   (func_rwbar),
        .func_cs_i      (func_cs),
        .func_rdata_o   (func_rdata[gi]),
        .mem_addr_o     (mem_addr[gi]),
        .mem_wdata_o    (mem_wdata[gi]),
        .mem_rwbar_o    (mem_rwbar[gi]),
        .mem_cs_o       (mem_cs[gi]),
        .mem_rdata_i    (mem_rdata[gi])
      );

      logic [DW-1:0] sram [64];
      logic [DW-1:0] rd_q;
      logic          rd_v = 1'b0;
      logic          hit;
      assign hit = (mem_addr[gi] == fault_addr[gi]);

      always @(posedge clk) begin
        if (mem_cs[gi] && !mem_rwbar[gi]) sram[mem_addr[gi]] <= mem_wdata[gi];
        rd_v <= mem_cs[gi] && mem_rwbar[gi];
        if (mem_cs[gi] && mem_rwbar[gi])
          rd_q <= (sram[mem_addr[gi]] & ~(hit ? sa0_mask[gi] : 8'h00))
                | (hit ? sa1_mask[gi] : 8'h00);
      end
      assign mem_rdata[gi] = (rd_v && mem_cs[gi] && mem_rwbar[gi]) ? rd_q : 8'h00;
    end
  endgenerate

  typedef struct {
    int len;
    int ok;
    int fa;
    int fd;
    int fe;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] rd_sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_bist(input int k, input exp_t e, input bit poke);
    exp_t x;
    int   cnt;
    @(negedge clk);
    start[k] = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start[k] = 1'b0;
    check("first_wr", {mem_cs[k], mem_rwbar[k], mem_addr[k], mem_wdata[k]},
          {1'b1, 1'b0, 6'd0, 8'h00});
    check("start_clr", {done[k], pass[k], fail_addr[k], fail_data[k], fail_elem[k]}, 32'd0);
    cnt = 0;
    while (busy[k] && cnt < 3000) begin
      cnt++;
      start[k] = poke && (cnt == 100);
      @(negedge clk);
    end
    start[k] = 1'b0;
    x = sb.pop_front();
    check("run_len", cnt, x.len);
    check("done", done[k], 1);
    check("pass", pass[k], x.ok);
    check("fail_addr", fail_addr[k], x.fa);
    check("fail_data", fail_data[k], x.fd);
    check("fail_elem", fail_elem[k], x.fe);
    repeat (4) @(negedge clk);
    check("done_hold", {busy[k], done[k]}, 2'b01);
    $display("run inst=%0d len=%0d pass=%0d fail_addr=%0d fail_data=%02h fail_elem=%0d",
             k, cnt, pass[k], fail_addr[k], fail_data[k], fail_elem[k]);
  endtask

  task automatic abort_run(input int k, input int at);
    int cnt;
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    cnt = 0;
    while (busy[k] && cnt < at) begin
      cnt++;
      if (cnt < at) @(negedge clk);
    end
    check("abort_reach", cnt, at);
    func_cs    = 1'b1;
    func_rwbar = 1'b1;
    func_addr  = 6'd42;
    rst_n      = 1'b0;
    #1;
    check("abort_state", {busy[k], done[k], pass[k]}, 3'b000);
    check("abort_mem", {mem_cs[k], mem_addr[k]}, {1'b1, 6'd42});
    $display("abort inst=%0d at busy cycle %0d", k, cnt);
    @(negedge clk);
    rst_n   = 1'b1;
    func_cs = 1'b0;
  endtask

  exp_t e;

  initial begin
    rst_n      = 1'b0;
    start[0]   = 1'b0;
    start[1]   = 1'b0;
    func_addr  = '0;
    func_wdata = '0;
    func_rwbar = 1'b1;
    func_cs    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fault_addr[i] = '0;
      sa0_mask[i]   = '0;
      sa1_mask[i]   = '0;
    end
    #12;
    check("rst_state", {busy[0], done[0], pass[0], fail_addr[0], fail_data[0], fail_elem[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle pass-through: write then read back through the functional port.
    @(negedge clk);
    func_cs = 1'b1; func_rwbar = 1'b0; func_addr = 6'd9; func_wdata = 8'hA5;
    #1;
    check("pt_wr", {mem_cs[0], mem_rwbar[0], mem_addr[0], mem_wdata[0]},
          {1'b1, 1'b0, 6'd9, 8'hA5});
    @(negedge clk);
    func_rwbar = 1'b1;
    rd_sb.push_back(8'hA5);
    @(negedge clk);
    check("pt_rd", func_rdata[0], rd_sb.pop_front());
    $display("func write/read addr 9 rdata=%02h", func_rdata[0]);
    func_cs = 1'b0;

    e = '{len: 960, ok: 1, fa: 0, fd: 0, fe: 0};
    run_bist(0, e, 1'b1);

    fault_addr[0] = 6'd17; sa1_mask[0] = 8'h08;
    e = '{len: 117, ok: 0, fa: 17, fd: 8'h08, fe: 1};
    run_bist(0, e, 1'b0);

    sa1_mask[0] = 8'h00;
    e = '{len: 960, ok: 1, fa: 0, fd: 0, fe: 0};
    run_bist(0, e, 1'b0);

    fault_addr[1] = 6'd63; sa0_mask[1] = 8'h01;
    e = '{len: 960, ok: 0, fa: 63, fd: 8'hFE, fe: 2};
    run_bist(1, e, 1'b0);

    sa0_mask[1] = 8'h00;
    abort_run(1, 300);
    e = '{len: 960, ok: 1, fa: 0, fd: 0, fe: 0};
    run_bist(1, e, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
